// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state and request record for the data-memory bus slave.
// Lane helpers here are pure functions, combinational, no flow control.
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] be;
    logic       misalign;
  } lane_t;

  // Request fields latched at capture; word index is kept separately since its width is a parameter.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [1:0]  off;
    logic [3:0]  be;
    logic        err;
    logic [31:0] wdat;
  } req_t;

  // Big-endian: byte offset 0 lands on be[3] / bits [31:24].
  function automatic lane_t lane_decode(input logic [1:0] size, input logic [1:0] off);
    lane_t l;
    l.be       = 4'b0000;
    l.misalign = 1'b0;
    case (size)
      SZ_WORD: begin
        l.be       = 4'b1111;
        l.misalign = (off != 2'b00);
      end
      SZ_HALF: begin
        l.be       = off[1] ? 4'b0011 : 4'b1100;
        l.misalign = off[0];
      end
      SZ_BYTE: l.be = 4'b1000 >> off;
      default: l.be = 4'b0000;
    endcase
    return l;
  endfunction

  function automatic logic [31:0] load_align(input logic [1:0] size, input logic [1:0] off,
                                             input logic [31:0] rdat);
    logic [31:0] r;
    r = 32'h0;
    case (size)
      SZ_WORD: r = rdat;
      SZ_HALF: r = off[1] ? {16'h0, rdat[15:0]} : {16'h0, rdat[31:16]};
      SZ_BYTE: begin
        case (off)
          2'd0:    r = {24'h0, rdat[31:24]};
          2'd1:    r = {24'h0, rdat[23:16]};
          2'd2:    r = {24'h0, rdat[15:8]};
          default: r = {24'h0, rdat[7:0]};
        endcase
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Replicating the right-aligned store data lets the byte enables pick the lane.
  function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wdat);
    logic [31:0] r;
    case (size)
      SZ_HALF: r = {2{wdat[15:0]}};
      SZ_BYTE: r = {4{wdat[7:0]}};
      default: r = wdat;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// 2**ADDR_W x 32 synchronous RAM, byte-write enables (be[3] covers [31:24]).
// One-cycle registered read; read data holds until the next read; no backpressure.
module dmem_bank #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdat,
  output logic [31:0]       rdat
);

  logic [31:0] mem_q [2**ADDR_W];
  logic [31:0] rdat_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr][8*b +: 8] <= wdat[8*b +: 8];
      end
    end else if (en) begin
      rdat_q <= mem_q[addr];
    end
  end

  assign rdat = rdat_q;

endmodule

// File: rtl/dmem_bus_slave.sv
// Data-side bus slave: one active-low ACKD_n pulse per request, WAIT_CYC+1 cycles after capture.
// Core holds MREQ until acknowledged; a held request is not re-serviced until MREQ drops.
module dmem_bus_slave
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  output logic        ACKD_n,
  output logic        BUS_ERR
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYC);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] widx_q, widx_d;
  req_t              req_q, req_d;
  logic              ackd_n_q, ackd_n_d;
  logic              bus_err_q, bus_err_d;
  logic              oe_q, oe_d;

  lane_t             lane;
  logic              oor;
  logic              bank_en, bank_we;
  logic [ADDR_W-1:0] bank_addr;
  logic [31:0]       bank_wdat, bank_rdat, load_dat;

  always_comb begin
    lane = lane_decode(SIZE, DAD[1:0]);
    oor  = (DAD >> (ADDR_W + 2)) != 32'd0;

    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    req_d   = req_q;

    case (state_q)
      ST_IDLE: begin
        if (MREQ) begin
          widx_d      = DAD[ADDR_W+1:2];
          req_d.write = WRITE;
          req_d.size  = SIZE;
          req_d.off   = DAD[1:0];
          req_d.be    = lane.be;
          req_d.err   = lane.misalign | (SIZE == SZ_RSVD) | oor;
          if (WRITE) req_d.wdat = DDT;
          cnt_d       = WAIT_LD;
          state_d     = (WAIT_LD == 4'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A withdrawn request wins over expiry of the final wait cycle.
        if (!MREQ) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_DONE;
      ST_DONE: if (!MREQ) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs come straight from flops loaded with the decode of the next state.
    ackd_n_d  = (state_d != ST_ACK);
    bus_err_d = (state_d == ST_ACK) & req_d.err;
    oe_d      = (state_d == ST_ACK) & ~req_d.write;

    // Read is launched on the edge into ACK; the write lands on the edge leaving it.
    bank_we   = (state_q == ST_ACK) & req_q.write & ~req_q.err;
    bank_en   = bank_we | (state_d == ST_ACK);
    bank_addr = bank_we ? widx_q : widx_d;
    bank_wdat = store_align(req_q.size, req_q.wdat);

    load_dat  = req_q.err ? 32'h0 : load_align(req_q.size, req_q.off, bank_rdat);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      widx_q    <= '0;
      req_q     <= '0;
      ackd_n_q  <= 1'b1;
      bus_err_q <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      widx_q    <= widx_d;
      req_q     <= req_d;
      ackd_n_q  <= ackd_n_d;
      bus_err_q <= bus_err_d;
      oe_q      <= oe_d;
    end
  end

  dmem_bank #(
    .ADDR_W (ADDR_W)
  ) u_bank (
    .clk  (clk),
    .en   (bank_en),
    .we   (bank_we),
    .be   (req_q.be),
    .addr (bank_addr),
    .wdat (bank_wdat),
    .rdat (bank_rdat)
  );

  assign DDT     = oe_q ? load_dat : 'z;
  assign ACKD_n  = ackd_n_q;
  assign BUS_ERR = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_slave.sv
// Bench for dmem_bus_slave: instance 0 with WAIT_CYC=2, instance 1 with WAIT_CYC=0.
module tb_dmem_bus_slave;
  import dmem_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mreq    [2];
  logic        write   [2];
  logic [1:0]  size    [2];
  logic [31:0] dad     [2];
  logic [31:0] drv     [2];
  logic        drv_oe  [2];
  logic        ackd_n  [2];
  logic        bus_err [2];
  wire  [31:0] ddt_a, ddt_b;
  wire         z_a, z_b;

  int checks = 0;
  int errors = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  assign ddt_a = drv_oe[0] ? drv[0] : 'z;
  assign ddt_b = drv_oe[1] ? drv[1] : 'z;
  assign z_a   = (ddt_a === 32'hzzzz_zzzz);
  assign z_b   = (ddt_b === 32'hzzzz_zzzz);

  dmem_bus_slave #(.ADDR_W(10), .WAIT_CYC(2)) u_dut_w2 (
    .clk(clk), .rst(rst_n), .MREQ(mreq[0]), .WRITE(write[0]), .SIZE(size[0]),
    .DAD(dad[0]), .DDT(ddt_a), .ACKD_n(ackd_n[0]), .BUS_ERR(bus_err[0])
  );

  dmem_bus_slave #(.ADDR_W(10), .WAIT_CYC(0)) u_dut_w0 (
    .clk(clk), .rst(rst_n), .MREQ(mreq[1]), .WRITE(write[1]), .SIZE(size[1]),
    .DAD(dad[1]), .DDT(ddt_b), .ACKD_n(ackd_n[1]), .BUS_ERR(bus_err[1])
  );

  function automatic logic [31:0] ddt_val(input int i);
    return (i == 0) ? ddt_a : ddt_b;
  endfunction

  function automatic logic ddt_z(input int i);
    return (i == 0) ? z_a : z_b;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic rq, input logic wr, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    mreq[i]   = rq;
    write[i]  = wr;
    size[i]   = sz;
    dad[i]    = a;
    drv[i]    = d;
    drv_oe[i] = rq & wr;
  endtask

  // Entered #1 after a rising edge with the DUT idle; returns the same way.
  task automatic access(input int i, input vec_t v, input string nm);
    int          n;
    int          lat;
    logic        got, e, zbad;
    logic [31:0] rd;
    n = 0; got = 1'b0; e = 1'b0; zbad = 1'b0; rd = 32'h0;
    lat = (i == 0) ? 3 : 1;
    drive(i, 1'b1, v.wr, v.sz, v.addr, v.wdat);
    @(posedge clk);
    #1 drv_oe[i] = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ackd_n[i] == 1'b0) begin
        got = 1'b1;
        rd  = ddt_val(i);
        e   = bus_err[i];
        if (v.wr && !ddt_z(i)) zbad = 1'b1;
      end else if (!ddt_z(i)) begin
        zbad = 1'b1;
      end
    end
    chk({nm, " ack latency"}, 32'(n), 32'(lat));
    chk({nm, " bus_err"}, 32'(e), 32'(v.exp_err));
    if (!v.wr) chk({nm, " load data"}, rd, v.exp_rd);
    chk({nm, " ddt released outside load ack"}, 32'(zbad), 32'd0);
    @(posedge clk);
    #1 mreq[i] = 1'b0;
    @(negedge clk);
    chk({nm, " ack one cycle"}, 32'(ackd_n[i]), 32'd1);
    chk({nm, " ddt z after ack"}, 32'(ddt_z(i)), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   pulses;
    int   n;
    vec_t v;

    vecs[0]  = '{1'b1, SZ_WORD, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, SZ_WORD, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, SZ_BYTE, 32'h11,   32'h123456AA, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, SZ_WORD, 32'h10,   32'h0,        32'hDEAABEEF, 1'b0};
    vecs[4]  = '{1'b0, SZ_HALF, 32'h12,   32'h0,        32'h0000BEEF, 1'b0};
    vecs[5]  = '{1'b1, SZ_WORD, 32'h20,   32'h12345678, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, SZ_HALF, 32'h13,   32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b1, SZ_WORD, 32'h22,   32'hCAFEF00D, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, SZ_WORD, 32'h20,   32'h0,        32'h12345678, 1'b0};
    vecs[9]  = '{1'b0, SZ_BYTE, 32'h13,   32'h0,        32'h000000EF, 1'b0};
    vecs[10] = '{1'b0, SZ_HALF, 32'h10,   32'h0,        32'h0000DEAA, 1'b0};
    vecs[11] = '{1'b0, SZ_RSVD, 32'h10,   32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, SZ_WORD, 32'h1000, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b1, SZ_WORD, 32'h0,    32'h11223344, 32'h0,        1'b0};
    vecs[14] = '{1'b1, SZ_BYTE, 32'h1000, 32'h00000055, 32'h0,        1'b1};
    vecs[15] = '{1'b0, SZ_WORD, 32'h0,    32'h0,        32'h11223344, 1'b0};
    vecs[16] = '{1'b1, SZ_WORD, 32'hFFC,  32'h01020304, 32'h0,        1'b0};
    vecs[17] = '{1'b1, SZ_HALF, 32'hFFE,  32'hFFFF9988, 32'h0,        1'b0};
    vecs[18] = '{1'b1, SZ_HALF, 32'hFFC,  32'h00007766, 32'h0,        1'b0};
    vecs[19] = '{1'b0, SZ_WORD, 32'hFFC,  32'h0,        32'h77669988, 1'b0};
    vecs[20] = '{1'b1, SZ_HALF, 32'h21,   32'h0000AAAA, 32'h0,        1'b1};
    vecs[21] = '{1'b0, SZ_WORD, 32'h20,   32'h0,        32'h12345678, 1'b0};
    vecs[22] = '{1'b0, SZ_BYTE, 32'h10,   32'h0,        32'h000000DE, 1'b0};
    vecs[23] = '{1'b0, SZ_BYTE, 32'h12,   32'h0,        32'h000000BE, 1'b0};
    vecs[24] = '{1'b0, SZ_WORD, 32'h80000000, 32'h0,    32'h0,        1'b1};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, SZ_WORD, 32'h0, 32'h0);
    #12;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset ackd_n[%0d]", i), 32'(ackd_n[i]), 32'd1);
      chk($sformatf("reset bus_err[%0d]", i), 32'(bus_err[i]), 32'd0);
      chk($sformatf("reset ddt z[%0d]", i), 32'(ddt_z(i)), 32'd1);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < NVEC; k++) access(0, vecs[k], $sformatf("vec%0d", k));

    // Store withdrawn during WAIT: no ack, memory untouched.
    drive(0, 1'b1, 1'b1, SZ_WORD, 32'h20, 32'hBAD0BAD0);
    @(posedge clk);
    #1 drv_oe[0] = 1'b0;
    @(negedge clk) mreq[0] = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (!ackd_n[0]) pulses++;
    end
    chk("abort no ack", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    v = '{1'b0, SZ_WORD, 32'h20, 32'h0, 32'h12345678, 1'b0};
    access(0, v, "abort readback");

    // Request held well past ACK must be serviced once.
    drive(0, 1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
    @(posedge clk);
    pulses = 0;
    repeat (11) begin
      @(negedge clk);
      if (!ackd_n[0]) pulses++;
    end
    chk("held mreq single ack", 32'(pulses), 32'd1);
    mreq[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // Reset during the ACK cycle of a load releases outputs without waiting for a clock.
    drive(0, 1'b1, 1'b0, SZ_WORD, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    n = 0;
    while (ackd_n[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst-in-ack ack reached", 32'(ackd_n[0]), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst-in-ack ackd_n", 32'(ackd_n[0]), 32'd1);
    chk("rst-in-ack ddt z", 32'(ddt_z(0)), 32'd1);
    mreq[0] = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset during WAIT of a store drops the store.
    drive(0, 1'b1, 1'b1, SZ_WORD, 32'h10, 32'h0BADF00D);
    @(posedge clk);
    #1 drv_oe[0] = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst-in-wait ackd_n", 32'(ackd_n[0]), 32'd1);
    chk("rst-in-wait bus_err", 32'(bus_err[0]), 32'd0);
    chk("rst-in-wait ddt z", 32'(ddt_z(0)), 32'd1);
    mreq[0] = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{1'b0, SZ_WORD, 32'h10, 32'h0, 32'hDEAABEEF, 1'b0};
    access(0, v, "post-reset readback");

    // Zero wait states.
    v = '{1'b1, SZ_WORD, 32'h40, 32'h13572468, 32'h0, 1'b0};
    access(1, v, "w0 store");
    v = '{1'b0, SZ_WORD, 32'h40, 32'h0, 32'h13572468, 1'b0};
    access(1, v, "w0 load");
    v = '{1'b0, SZ_BYTE, 32'h41, 32'h0, 32'h00000057, 1'b0};
    access(1, v, "w0 load byte");
    v = '{1'b1, SZ_HALF, 32'h41, 32'h0000FFFF, 32'h0, 1'b1};
    access(1, v, "w0 misaligned store");
    v = '{1'b0, SZ_HALF, 32'h40, 32'h0, 32'h00001357, 1'b0};
    access(1, v, "w0 load half");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_bus_slave.md
# dmem_bus_slave

Data-memory bus slave sitting directly downstream of the multicycle processor top. Services the core's data-side requests (MREQ, WRITE, SIZE, DAD, DDT) against an internal byte-addressable RAM. Inserts a programmable number of wait states and answers each access with a one-cycle active-low acknowledge on ACKD_n. Handles big-endian byte lanes and flags misaligned or out-of-range accesses.

## Interface
- ADDR_W, 10: word-address width; RAM holds 2**ADDR_W 32-bit words; valid byte addresses are 0 to 4*2**ADDR_W-1.
- WAIT_CYC, 2: wait states between request capture and acknowledge; 0 to 15 allowed.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- MREQ  in  1  request valid, held by the core until acknowledged.
- WRITE  in  1  1 = store, 0 = load.
- SIZE  in  2  00 word, 01 halfword, 10 byte, 11 reserved.
- DAD  in  32  byte address.
- DDT  inout  32  store data from core when WRITE=1; load data from this block during the ACK cycle of a load; Z otherwise.
- ACKD_n  out  1  acknowledge, low for exactly one cycle per accepted request.
- BUS_ERR  out  1  high in the same cycle as ACKD_n low when the access was misaligned, out of range, or used SIZE=11.

## Operation
- FSM states: IDLE, WAIT, ACK, DONE.
- IDLE: on a rising edge with MREQ=1, latch DAD, WRITE, SIZE, and DDT (stores only), evaluate the error condition, and load the wait counter with WAIT_CYC. Go to WAIT, or to ACK directly if WAIT_CYC=0.
- WAIT: decrement the counter each cycle; when it reaches 0, go to ACK. If MREQ=0 is sampled in WAIT, the request is aborted: go to IDLE with no write and no ack.
- ACK:
  - ACKD_n=0 and BUS_ERR valid.
  - A store performs its byte-enabled RAM write on the edge leaving ACK, only if error-free.
  - A load drives DDT with the read data; on error it drives 0.
  - Next state is DONE.
- DONE: wait for MREQ=0, then go to IDLE. This blocks double-servicing of a still-held request.
- Endianness is big-endian: byte offset 0 maps to bits [31:24]; halfword offset 0 maps to [31:16].
- Load data is right-aligned and zero-extended into DDT[7:0] or DDT[15:0]. The core performs sign extension.
- Store data is taken right-aligned from DDT[7:0] or DDT[15:0].
- Error conditions:
  - halfword with DAD[0]=1;
  - word with DAD[1:0]≠0;
  - SIZE=11;
  - DAD[31:ADDR_W+2] nonzero.
  - An errored access is still acknowledged and never modifies the RAM.

## Timing
- Reset values: state IDLE, ACKD_n=1, BUS_ERR=0, DDT=Z, wait counter 0. RAM contents are not reset.
- Reset asserted mid-access forces IDLE immediately (asynchronously). A pending store is dropped.
- Latency: request sampled at edge k gives ACKD_n=0 during cycle k+1+WAIT_CYC.
- Accepted-request throughput is at most one per WAIT_CYC+3 cycles. The minimum case is ACK, then DONE seeing MREQ=0, then IDLE.
- DDT is driven only while state=ACK and the latched WRITE=0. This gives no contention with the core, which drives DDT only when WRITE=1.
- RAM read is synchronous: the read is issued on entry to the final WAIT cycle, or in IDLE capture when WAIT_CYC=0. Data is valid throughout ACK.
- ACKD_n and BUS_ERR are registered outputs (decoded from state flops), glitch-free.

## Structure
- Shared package dmem_pkg:
  - SIZE encodings SZ_WORD, SZ_HALF, SZ_BYTE;
  - FSM state enum;
  - function computing the 4-bit byte-enable and misalign flag from SIZE and DAD[1:0].
- One sub-module, dmem_bank: 2**ADDR_W x 32 synchronous RAM with 4 byte-write enables. Bit 3 of the enable covers [31:24].
- Top holds the FSM, latches, lane steering, and tri-state driver.

## Test plan
- WAIT_CYC=2, store word 0xDEADBEEF at 0x10, then load word 0x10 -> ACKD_n low exactly at cycle k+3 for each access; load returns 0xDEADBEEF; BUS_ERR=0.
- Store byte 0xAA at 0x11 over the prior word, then load word 0x10 -> 0xDEAABEEF. Load halfword 0x12 -> 0x0000BEEF.
- Load halfword 0x13 and store word 0x22 -> each acked with BUS_ERR=1; load returns 0; memory at 0x20 is unchanged on readback.
- Store with MREQ dropped during WAIT -> no ACKD_n pulse; readback shows old data. Also: MREQ held 5 cycles past ACK -> exactly one ACKD_n pulse.
- WAIT_CYC=0 -> ACKD_n low in the cycle right after capture; DDT is Z in every non-ACK cycle, including during stores.
- rst pulled low during WAIT of a store -> ACKD_n=1, DDT=Z immediately; after release, readback shows the old value and the next request is serviced normally.
